// File: rtl/vga_sync_gen.sv
// Purpose: VGA raster timing (pixel tick, h/v counters, syncs, active flag, line/frame strobes).
// Latency: decodes are combinational from the counters; counters advance on the edge where pix_tick=1.
// Backpressure: en=0 freezes the divider and counters; strobes are forced low while frozen.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int W        = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic         pix_tick,
    output logic [W-1:0] hcount,
    output logic [W-1:0] vcount,
    output logic         hsync,
    output logic         vsync,
    output logic         video_on,
    output logic         line_start,
    output logic         frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Divider needs at least one bit even when CLK_DIV=1 (it then sits at 0).
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [W-1:0]  H_LAST   = W'(H_TOTAL - 1);
    localparam logic [W-1:0]  V_LAST   = W'(V_TOTAL - 1);
    localparam logic [W-1:0]  H_VIS    = W'(H_ACTIVE);
    localparam logic [W-1:0]  V_VIS    = W'(V_ACTIVE);
    localparam logic [W-1:0]  HS_START = W'(H_ACTIVE + H_FP);
    localparam logic [W-1:0]  HS_END   = W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [W-1:0]  VS_START = W'(V_ACTIVE + V_FP);
    localparam logic [W-1:0]  VS_END   = W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt;
    logic          h_wrap;

    // Pixel tick and end-of-line/end-of-frame strobes, all gated by en via pix_tick.
    always_comb begin
        pix_tick    = en && (div_cnt == DIV_LAST);
        h_wrap      = (hcount == H_LAST);
        line_start  = pix_tick && h_wrap;
        frame_start = line_start && (vcount == V_LAST);
    end

    // Clock divider: counts enabled clocks, holds its phase while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
    end

    // Raster position: column advances per pixel tick, line advances at column wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_tick) begin
            if (!h_wrap) begin
                hcount <= hcount + W'(1);
            end else begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + W'(1);
            end
        end
    end

    // Level decodes straight off the counters, so they line up with hcount/vcount.
    always_comb begin
        hsync    = ((hcount >= HS_START) && (hcount < HS_END)) ? HS_POL : ~HS_POL;
        vsync    = ((vcount >= VS_START) && (vcount < VS_END)) ? VS_POL : ~VS_POL;
        video_on = (hcount < H_VIS) && (vcount < V_VIS);
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose: randomized check of vga_sync_gen against an arithmetic raster model.
// Latency: outputs sampled 2 time units after each rising edge, after en is updated.
// Backpressure: en is toggled randomly and in directed holds; the model tracks enabled clocks.
module tb_vga_sync_gen;

    // Reduced raster so several full frames fit in a short run.
    localparam int HA = 20, HF = 3, HS = 5, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int CD = 3;
    localparam bit HP = 1'b0, VP = 1'b0;
    localparam int WD = 10;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT * CD;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          pix_tick;
    logic [WD-1:0] hcount;
    logic [WD-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          line_start;
    logic          frame_start;

    int total = 0;
    int bad   = 0;
    // Model state: number of enabled clocks since the last reset release.
    int n = 0;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .HS_POL(HP), .VS_POL(VP), .W(WD)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s obs=%0d exp=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model position from elapsed pixels; levels from the raster window rules.
    function automatic int m_h();
        return (n / CD) % HT;
    endfunction
    function automatic int m_v();
        return ((n / CD) / HT) % VT;
    endfunction

    task automatic check_all();
        int h, v, tick, ls, fs;
        h    = m_h();
        v    = m_v();
        tick = (en && rst && (n % CD) == CD - 1) ? 1 : 0;
        ls   = (tick && h == HT - 1) ? 1 : 0;
        fs   = (ls && v == VT - 1) ? 1 : 0;
        chk("hcount", int'(hcount), h);
        chk("vcount", int'(vcount), v);
        chk("pix_tick", int'(pix_tick), tick);
        chk("line_start", int'(line_start), ls);
        chk("frame_start", int'(frame_start), fs);
        chk("hsync", int'(hsync), (h >= HA + HF && h < HA + HF + HS) ? int'(HP) : int'(!HP));
        chk("vsync", int'(vsync), (v >= VA + VF && v < VA + VF + VS) ? int'(VP) : int'(!VP));
        chk("video_on", int'(video_on), (h < HA && v < VA) ? 1 : 0);
    endtask

    // One clock: model absorbs the edge, then en for the next cycle is applied and outputs checked.
    task automatic cycle(input logic en_next);
        @(posedge clk);
        if (en && rst) n++;
        #1 en = en_next;
        #1 check_all();
    endtask

    initial begin
        int seen, last;
        bit found;
        rst = 1'b0;
        en  = 1'b1;

        // Reset held with en=1: everything at decode-of-(0,0) values.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_hcount", int'(hcount), 0);
        chk("rst_vcount", int'(vcount), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_video_on", int'(video_on), 1);
        chk("rst_pix_tick", int'(pix_tick), 0);
        check_all();

        // Release between edges; first tick appears on the CD-th enabled clock.
        #3 rst = 1'b1;
        for (int i = 0; i < CD - 1; i++) begin
            cycle(1'b1);
            chk("early_tick", int'(pix_tick), (i == CD - 2) ? 1 : 0);
        end
        cycle(1'b1);
        chk("first_hcount", int'(hcount), 1);

        // Directed line wrap at line 5.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            cycle(1'b1);
            if (int'(hcount) == HT - 1 && int'(vcount) == 5 && pix_tick) found = 1'b1;
        end
        chk("wrap_found", int'(found), 1);
        chk("wrap_line_start", int'(line_start), 1);
        chk("wrap_frame_start", int'(frame_start), 0);
        cycle(1'b1);
        chk("wrap_hcount", int'(hcount), 0);
        chk("wrap_vcount", int'(vcount), 6);

        // Directed hold: freeze for 10 clocks mid-line, then resume.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            cycle(1'b1);
            if (int'(hcount) == 10 && int'(vcount) == 8) found = 1'b1;
        end
        chk("hold_found", int'(found), 1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0);
            chk("hold_h", int'(hcount), 10);
        end
        for (int i = 0; i < 2 * CD; i++) cycle(1'b1);

        // Frame period with en held high.
        seen = 0;
        last = 0;
        for (int i = 0; i < 3 * FRAME && seen < 2; i++) begin
            cycle(1'b1);
            if (frame_start) begin
                if (seen == 1) chk("frame_period", i - last, FRAME);
                last = i;
                seen++;
            end
        end
        chk("frame_seen", seen, 2);

        // Randomized en over more than one frame.
        for (int i = 0; i < 2500; i++) cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

        // Asynchronous reset mid-frame, asserted between edges.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            cycle(1'b1);
            if (int'(hcount) == 22 && int'(vcount) == 13) found = 1'b1;
        end
        chk("arst_found", int'(found), 1);
        #3 rst = 1'b0;
        n = 0;
        #1;
        chk("arst_hcount", int'(hcount), 0);
        chk("arst_vcount", int'(vcount), 0);
        check_all();
        cycle(1'b1);
        cycle(1'b1);
        #3 rst = 1'b1;
        for (int i = 0; i < 600; i++) cycle(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
